// File: rtl/cell_mem_ctrl.sv
// ---------------------------------------------------------------------------
// cell_mem_ctrl
//
// Request-side controller for the single-port cell RAM (registered read
// address, one-cycle read latency). Accepts read / write / alloc requests
// from the reduction core, drives the RAM pins from registers, waits out the
// RAM read latency and returns exactly one response per accepted request.
// A bump-pointer allocator hands out fresh cell addresses for alloc requests.
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high. The requester holds req_op/req_addr/req_data
// stable while req_valid is high and req_ready is low. req_ready is high only
// while the controller is IDLE. Responses are a single-cycle rsp_valid pulse
// with no backpressure; rsp_err qualifies that pulse.
//
// Ports
//   clock, reset_n          clock, asynchronous active-low reset
//   req_valid/ready         request handshake
//   req_op                  00 read, 01 write, 10 alloc, 11 reserved (error)
//   req_addr, req_data      target address (read/write), payload (write/alloc)
//   free_clear              rewinds the free pointer to FREE_BASE (IDLE only)
//   rsp_valid/data/addr/err response pulse and its fields
//   free_ptr, heap_full     allocator pointer and its exhaustion flag
//   mem_data/address/wren   registered RAM drive
//   mem_q                   RAM read data
//   dbg_state               current controller state (0 IDLE, 1 ISSUE, 2 WAIT)
// ---------------------------------------------------------------------------
module cell_mem_ctrl #(
    parameter int DATA_W    = 68,
    parameter int ADDR_W    = 10,
    parameter int FREE_BASE = 0,
    parameter int MEM_TOP   = 1023
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    input  logic              free_clear,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic              rsp_err,
    output logic [ADDR_W:0]   free_ptr,
    output logic              heap_full,
    output logic [DATA_W-1:0] mem_data,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_q,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_ALLOC = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    // Pointer-width copies of the parameters so every compare is unsigned
    // and width-matched; the pointer has one spare bit to express "full".
    localparam logic [ADDR_W:0] TOP_W   = (ADDR_W+1)'(MEM_TOP);
    localparam logic [ADDR_W:0] BASE_W  = (ADDR_W+1)'(FREE_BASE);
    localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W+1)'(1);

    state_t            state;
    logic [1:0]        op_q;
    logic [ADDR_W-1:0] addr_q;
    logic              err_q;

    logic              accept;
    logic              addr_bad;
    logic              req_err;
    logic              req_stores;
    logic [ADDR_W-1:0] tgt_addr;

    assign req_ready = (state == IDLE);
    assign heap_full = (free_ptr > TOP_W);
    assign dbg_state = state;

    always_comb begin
        accept     = req_valid && (state == IDLE);
        addr_bad   = ({1'b0, req_addr} > TOP_W);
        tgt_addr   = (req_op == OP_ALLOC) ? free_ptr[ADDR_W-1:0] : req_addr;
        req_err    = (req_op == OP_RSVD)
                   || (((req_op == OP_READ) || (req_op == OP_WRITE)) && addr_bad)
                   || ((req_op == OP_ALLOC) && heap_full);
        req_stores = !req_err && ((req_op == OP_WRITE) || (req_op == OP_ALLOC));
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            op_q        <= OP_READ;
            addr_q      <= '0;
            err_q       <= 1'b0;
            free_ptr    <= BASE_W;
            rsp_valid   <= 1'b0;
            rsp_err     <= 1'b0;
            rsp_data    <= '0;
            rsp_addr    <= '0;
            mem_wren    <= 1'b0;
            mem_address <= '0;
            mem_data    <= '0;
        end else begin
            // rsp_valid is a pulse: only the response edge raises it.
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q        <= req_op;
                        addr_q      <= tgt_addr;
                        err_q       <= req_err;
                        mem_address <= tgt_addr;
                        mem_data    <= req_data;
                        mem_wren    <= req_stores;
                        if (!req_err && (req_op == OP_ALLOC)) begin
                            free_ptr <= free_ptr + PTR_ONE;
                        end
                        state <= ISSUE;
                    end
                    // Placed after the alloc bump so a coincident clear wins:
                    // the alloc still used the old pointer value above.
                    if (free_clear) begin
                        free_ptr <= BASE_W;
                    end
                end
                ISSUE: begin
                    // The RAM samples wren/address/data on this edge.
                    mem_wren <= 1'b0;
                    if ((op_q == OP_READ) && !err_q) begin
                        state <= WAIT;
                    end else begin
                        state     <= IDLE;
                        rsp_valid <= 1'b1;
                        rsp_addr  <= addr_q;
                        rsp_err   <= err_q;
                        rsp_data  <= '0;
                    end
                end
                WAIT: begin
                    // mem_q now holds the word addressed on the ISSUE edge.
                    state     <= IDLE;
                    rsp_valid <= 1'b1;
                    rsp_addr  <= addr_q;
                    rsp_err   <= 1'b0;
                    rsp_data  <= mem_q;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cell_mem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cell_mem_ctrl
//
// Two controllers share one stimulus stream: "dut" with the full 1024-word
// heap (backed by a behavioural RAM) and "dut_s" with MEM_TOP = 3 for the
// heap-full and out-of-range cases. A per-cycle compare process checks dut
// against a transaction-level model (memory array, pointer, expected-response
// queue with due cycles); directed sections pin that model with literals.
// ---------------------------------------------------------------------------
module tb_cell_mem_ctrl;

    localparam int DW  = 68;
    localparam int AW  = 10;
    localparam int TOP = 1023;
    localparam int EW  = 16 + 1 + AW + DW;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    // ---------------- shared stimulus ----------------
    logic          req_valid;
    logic [1:0]    req_op;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_data;
    logic          free_clear;

    // ---------------- dut outputs ----------------
    logic          req_ready, rsp_valid, rsp_err, heap_full, mem_wren;
    logic [DW-1:0] rsp_data, mem_data, mem_q;
    logic [AW-1:0] rsp_addr, mem_address;
    logic [AW:0]   free_ptr;
    logic [1:0]    dbg_state;

    // ---------------- dut_s outputs ----------------
    logic          s_req_ready, s_rsp_valid, s_rsp_err, s_heap_full, s_mem_wren;
    logic [DW-1:0] s_rsp_data, s_mem_data;
    logic [DW-1:0] s_mem_q = '0;
    logic [AW-1:0] s_rsp_addr, s_mem_address;
    logic [AW:0]   s_free_ptr;
    logic [1:0]    s_dbg_state;

    cell_mem_ctrl #(.DATA_W(DW), .ADDR_W(AW), .FREE_BASE(0), .MEM_TOP(TOP)) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_data(req_data), .free_clear(free_clear),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_addr(rsp_addr),
        .rsp_err(rsp_err), .free_ptr(free_ptr), .heap_full(heap_full),
        .mem_data(mem_data), .mem_address(mem_address), .mem_wren(mem_wren),
        .mem_q(mem_q), .dbg_state(dbg_state)
    );

    cell_mem_ctrl #(.DATA_W(DW), .ADDR_W(AW), .FREE_BASE(0), .MEM_TOP(3)) dut_s (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(s_req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_data(req_data), .free_clear(free_clear),
        .rsp_valid(s_rsp_valid), .rsp_data(s_rsp_data), .rsp_addr(s_rsp_addr),
        .rsp_err(s_rsp_err), .free_ptr(s_free_ptr), .heap_full(s_heap_full),
        .mem_data(s_mem_data), .mem_address(s_mem_address), .mem_wren(s_mem_wren),
        .mem_q(s_mem_q), .dbg_state(s_dbg_state)
    );

    // ---------------- behavioural RAM (registered read address) ----------------
    logic [DW-1:0] ram [0:1023];
    logic [AW-1:0] ram_addr_q = '0;
    initial for (int i = 0; i < 1024; i++) ram[i] = '0;
    always @(posedge clock) begin
        if (mem_wren) ram[mem_address] <= mem_data;
        ram_addr_q <= mem_address;
    end
    assign mem_q = ram[ram_addr_q];

    // ---------------- check bookkeeping ----------------
    int n_checks = 0;
    int n_errors = 0;

    function automatic void chk(input string name, input logic [127:0] act,
                                input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic void fail_now(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: bound expired (t=%0t)", name, $time);
    endfunction

    function automatic logic [DW-1:0] rnd68();
        return {4'($urandom), $urandom, $urandom};
    endfunction

    // ---------------- transaction-level model ----------------
    logic [DW-1:0] model_mem [0:1023];
    logic [EW-1:0] exp_q[$];
    int            model_fp;
    int            cyc = 0;
    int            busy_until;
    int            wren_at;
    logic [AW-1:0] wren_addr;
    logic [DW-1:0] wren_data;
    int            pw_due;
    logic [AW-1:0] pw_addr;
    logic [DW-1:0] pw_data;
    bit            chk_en = 1'b0;

    initial for (int i = 0; i < 1024; i++) model_mem[i] = '0;

    task automatic model_reset();
        exp_q.delete();
        model_fp   = 0;
        busy_until = 0;
        wren_at    = -1;
        pw_due     = -1;
    endtask

    // Per-cycle compare: outputs seen at this falling edge reflect the last
    // rising edge; afterwards predict what the coming rising edge accepts.
    logic [EW-1:0] ce;
    bit            exp_ready;
    bit            p_err;
    logic [AW-1:0] p_addr;
    logic [DW-1:0] p_data;
    int            p_due;

    always @(negedge clock) begin
        if (chk_en) begin
            cyc++;
            if (pw_due == cyc) model_mem[pw_addr] = pw_data;

            if (exp_q.size() > 0 && int'(exp_q[0][EW-1 -: 16]) == cyc) begin
                ce = exp_q.pop_front();
                chk("rsp_valid", rsp_valid, 1);
                chk("rsp_data", rsp_data, ce[DW-1:0]);
                chk("rsp_addr", rsp_addr, ce[DW+AW-1:DW]);
                chk("rsp_err", rsp_err, ce[DW+AW]);
            end else begin
                chk("rsp_quiet", rsp_valid, 0);
            end

            exp_ready = (busy_until <= cyc);
            chk("req_ready", req_ready, exp_ready);
            chk("mem_wren", mem_wren, (wren_at == cyc));
            if (wren_at == cyc) begin
                chk("mem_address", mem_address, wren_addr);
                chk("mem_data", mem_data, wren_data);
            end
            chk("free_ptr", free_ptr, model_fp);
            chk("heap_full", heap_full, (model_fp > TOP));

            if (exp_ready && req_valid) begin
                p_data = '0;
                p_addr = req_addr;
                case (req_op)
                    2'b00: begin
                        p_err = (int'(req_addr) > TOP);
                        if (!p_err) p_data = model_mem[req_addr];
                    end
                    2'b01: p_err = (int'(req_addr) > TOP);
                    2'b10: begin
                        p_err  = (model_fp > TOP);
                        p_addr = AW'(model_fp);
                    end
                    default: p_err = 1'b1;
                endcase
                p_due = cyc + ((req_op == 2'b00 && !p_err) ? 3 : 2);
                if (!p_err && (req_op == 2'b01 || req_op == 2'b10)) begin
                    wren_at   = cyc + 1;
                    wren_addr = p_addr;
                    wren_data = req_data;
                    pw_due    = cyc + 2;
                    pw_addr   = p_addr;
                    pw_data   = req_data;
                    if (req_op == 2'b10) model_fp++;
                end
                exp_q.push_back({16'(p_due), p_err, p_addr, p_data});
                busy_until = p_due;
            end
            if (exp_ready && free_clear) model_fp = 0;
        end
    end

    // ---------------- driver tasks ----------------
    // Inputs change 1 time unit after a rising edge; a request is offered
    // until a falling edge sees req_ready, then transfers on the next edge.
    task automatic send(input logic [1:0] op, input logic [AW-1:0] addr,
                        input logic [DW-1:0] data, input logic clr);
        bit ok;
        ok         = 1'b0;
        req_op     = op;
        req_addr   = addr;
        req_data   = data;
        free_clear = clr;
        req_valid  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (req_ready) begin
                @(posedge clock);
                #1;
                ok = 1'b1;
                break;
            end
        end
        free_clear = 1'b0;
        if (!ok) fail_now("accept_timeout");
    endtask

    task automatic idle();
        req_valid  = 1'b0;
        free_clear = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Captured response, counted in rising edges after the acceptance edge.
    int            c_lat;
    logic [DW-1:0] c_data, s_c_data;
    logic [AW-1:0] c_addr, s_c_addr;
    logic          c_err, s_c_err, s_c_valid, c_wren, s_c_wren;

    task automatic wait_rsp();
        bit got;
        got      = 1'b0;
        c_lat    = 0;
        c_wren   = mem_wren;
        s_c_wren = s_mem_wren;
        for (int i = 0; i < 8; i++) begin
            @(posedge clock);
            #1;
            c_lat++;
            if (rsp_valid) begin
                c_data    = rsp_data;
                c_addr    = rsp_addr;
                c_err     = rsp_err;
                s_c_valid = s_rsp_valid;
                s_c_data  = s_rsp_data;
                s_c_addr  = s_rsp_addr;
                s_c_err   = s_rsp_err;
                got       = 1'b1;
                break;
            end
            c_wren   = c_wren | mem_wren;
            s_c_wren = s_c_wren | s_mem_wren;
        end
        if (!got) fail_now("rsp_timeout");
    endtask

    // ---------------- directed + random sequence ----------------
    logic [DW-1:0] a_pay [0:2];
    logic [DW-1:0] wv;
    logic [1:0]    r_op;
    logic [AW-1:0] r_addr;
    int            r;

    initial begin
        reset_n    = 1'b0;
        req_valid  = 1'b0;
        req_op     = 2'b00;
        req_addr   = '0;
        req_data   = '0;
        free_clear = 1'b0;
        cycles(3);
        reset_n = 1'b1;

        // Reset state
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_addr", rsp_addr, 0);
        chk("rst_mem_wren", mem_wren, 0);
        chk("rst_mem_address", mem_address, 0);
        chk("rst_mem_data", mem_data, 0);
        chk("rst_free_ptr", free_ptr, 0);
        chk("rst_heap_full", heap_full, 0);
        chk("rst_req_ready", req_ready, 1);
        model_reset();
        chk_en = 1'b1;

        // Small heap: four allocs succeed at 0..3, the fifth errors
        for (int i = 0; i < 4; i++) begin
            send(2'b10, 10'd0, rnd68(), 1'b0);
            idle();
            wait_rsp();
            chk("s_alloc_lat", c_lat, 1);
            chk("s_alloc_valid", s_c_valid, 1);
            chk("s_alloc_addr", s_c_addr, i);
            chk("s_alloc_err", s_c_err, 0);
        end
        send(2'b10, 10'd0, rnd68(), 1'b0);
        idle();
        wait_rsp();
        chk("s_full_err", s_c_err, 1);
        chk("s_full_wren", s_c_wren, 0);
        chk("s_full_data", s_c_data, 0);
        chk("s_full_ptr", s_free_ptr, 4);
        chk("s_heap_full", s_heap_full, 1);
        chk("main_ptr", free_ptr, 5);

        // Write to MEM_TOP+1 on the small heap, legal on the big one
        send(2'b01, 10'd4, rnd68(), 1'b0);
        idle();
        wait_rsp();
        chk("s_oor_lat", c_lat, 1);
        chk("s_oor_err", s_c_err, 1);
        chk("s_oor_wren", s_c_wren, 0);
        chk("s_oor_data", s_c_data, 0);
        chk("big_wr4_wren", c_wren, 1);
        chk("big_wr4_err", c_err, 0);

        // Reserved op
        send(2'b11, 10'd7, rnd68(), 1'b0);
        idle();
        wait_rsp();
        chk("rsvd_lat", c_lat, 1);
        chk("rsvd_err", c_err, 1);
        chk("rsvd_data", c_data, 0);
        chk("rsvd_wren", c_wren, 0);

        // Write then read address 5
        wv = 68'h1_2345_6789_ABCD_EF01;
        send(2'b01, 10'd5, wv, 1'b0);
        idle();
        wait_rsp();
        chk("wr5_lat", c_lat, 1);
        chk("wr5_err", c_err, 0);
        chk("wr5_addr", c_addr, 5);
        send(2'b00, 10'd5, '0, 1'b0);
        idle();
        wait_rsp();
        chk("rd5_lat", c_lat, 2);
        chk("rd5_data", c_data, wv);
        chk("rd5_err", c_err, 0);

        // Clear the pointer, then three allocs land at 0, 1, 2
        free_clear = 1'b1;
        cycles(1);
        free_clear = 1'b0;
        chk("clear_ptr", free_ptr, 0);
        for (int i = 0; i < 3; i++) begin
            a_pay[i] = rnd68();
            send(2'b10, 10'h3ff, a_pay[i], 1'b0);
            idle();
            wait_rsp();
            chk("alloc_addr", c_addr, i);
            chk("alloc_err", c_err, 0);
        end
        chk("alloc_ptr", free_ptr, 3);
        for (int i = 0; i < 3; i++) begin
            send(2'b00, AW'(i), '0, 1'b0);
            idle();
            wait_rsp();
            chk("alloc_readback", c_data, a_pay[i]);
        end

        // Alloc coinciding with free_clear: uses old pointer, ends at base
        send(2'b10, 10'd0, rnd68(), 1'b1);
        idle();
        chk("clr_alloc_ptr", free_ptr, 0);
        wait_rsp();
        chk("clr_alloc_addr", c_addr, 3);

        // req_valid held with alternating write/read
        for (int i = 0; i < 8; i++) begin
            send(2'b01, AW'(40 + i), rnd68(), 1'b0);
            send(2'b00, AW'(40 + i), '0, 1'b0);
        end
        idle();
        cycles(4);

        // Randomised traffic
        for (int k = 0; k < 400; k++) begin
            r = $urandom_range(0, 99);
            r_op = (r < 35) ? 2'b00 : (r < 70) ? 2'b01 : (r < 90) ? 2'b10 : 2'b11;
            r_addr = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 1023))
                                                 : AW'($urandom_range(0, 31));
            send(r_op, r_addr, rnd68(), ($urandom_range(0, 29) == 0));
            if ($urandom_range(0, 1) == 1) begin
                idle();
                cycles($urandom_range(0, 2));
            end
        end
        idle();
        cycles(5);
        chk("drain", exp_q.size(), 0);

        // Reset while a write sits in ISSUE: wren drops at once, no RAM write
        send(2'b01, 10'd20, rnd68(), 1'b0);
        idle();
        chk("issue_wren", mem_wren, 1);
        chk_en  = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("rst_issue_wren", mem_wren, 0);
        chk("rst_issue_state", dbg_state, 0);
        cycles(2);
        reset_n = 1'b1;
        model_reset();
        chk_en = 1'b1;
        send(2'b00, 10'd20, '0, 1'b0);
        idle();
        cycles(4);

        // Reset while a read sits in WAIT: no response afterwards
        send(2'b10, 10'd0, rnd68(), 1'b0);
        idle();
        cycles(2);
        send(2'b00, 10'd5, '0, 1'b0);
        idle();
        cycles(1);
        chk("wait_state", dbg_state, 2);
        chk_en  = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("rst_wait_wren", mem_wren, 0);
        chk("rst_wait_rsp", rsp_valid, 0);
        chk("rst_wait_ptr", free_ptr, 0);
        chk("rst_wait_ready", req_ready, 1);
        cycles(2);
        reset_n = 1'b1;
        model_reset();
        chk_en = 1'b1;
        cycles(6);
        chk("post_rst_state", dbg_state, 0);
        chk("post_rst_drain", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete (t=%0t)", $time);
        $fatal(1);
    end

endmodule
